dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Shares the single data memory port between two requesters: the CPU memory stage and the program/data loader used for test preload and result dump. Each requester gets a request/done handshake. The arbiter sequences each access over a configurable memory latency and drives the data memory's read/write strobes, address and write data. It sits between the memory-stage control signals and the data memory instance, replacing their direct connection.

## Interface
Parameters:
- DATA_W, default `WORD (64): address and data width.
- MEM_LAT, default 1: cycles a strobe is held per access; legal range ≥1.

Ports:
- clk, input, 1: single clock for all state. One clock only.
- reset, input, 1: synchronous, active-high.
- cpu_req, input, 1: CPU access request. Held with cpu_we/addr/wdata stable until cpu_done.
- cpu_we, input, 1: 1 = write, 0 = read.
- cpu_addr, input, DATA_W: byte address.
- cpu_wdata, input, DATA_W: write data.
- cpu_gnt, output, 1: CPU owns the memory this cycle.
- cpu_done, output, 1: one-cycle completion pulse.
- cpu_rdata, output, DATA_W: read data, valid while cpu_done=1 for reads.
- ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_gnt, ldr_done, ldr_rdata: same directions, widths and meanings, for the loader.
- mem_read, output, 1: data memory read strobe.
- mem_write, output, 1: data memory write strobe.
- mem_address, output, DATA_W: memory address.
- mem_write_data, output, DATA_W: memory write data.
- mem_read_data, input, DATA_W: memory read data, valid in the last strobe cycle.

## Operation
- FSM states are IDLE, ACCESS and DONE.
- IDLE → ACCESS when any req=1. The winner is latched as owner, along with its we/addr/wdata. The wait counter loads MEM_LAT-1.
- ACCESS:
  - owner gnt=1.
  - mem_read = !we, mem_write = we. The two strobes are never both 1.
  - mem_address and mem_write_data come from the latched values.
  - The counter decrements each cycle. When it reaches 0, mem_read_data is captured (reads only) and the FSM moves to DONE.
- DONE: owner done=1 and owner rdata = captured word for one cycle, then → IDLE.
- All gnt, done and strobe outputs are 0 outside their states. mem_address and mem_write_data are 0 in IDLE and DONE. rdata holds its last captured value.
- Requester rule: deassert req, or present a new request, on the edge that ends the done cycle. IDLE then samples only fresh requests.
- Arbitration happens only in IDLE. A request arriving during ACCESS or DONE waits.
- Changing we/addr/wdata while req is pending has no effect: the values are latched at grant.

## Timing
- Request sampled in IDLE at cycle 0:
  - gnt and strobe run from cycle 1 through cycle MEM_LAT.
  - done is asserted at cycle MEM_LAT+1.
- Throughput: one access per MEM_LAT+2 cycles.
- Reset values: state IDLE, all outputs 0, rdata 0, last-served pointer = loader.
- Reset asserted in any state: at the next edge the state returns to IDLE and all strobes, gnt and done go to 0. The aborted access produces no done. A write already strobed may have reached memory.
- Counter width is $clog2(MEM_LAT+1). There is no wrap, because the counter reloads on every grant.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin arbitration. When both requesters are pending in IDLE, the one not served last wins. The last-served pointer updates on each grant. Worst-case wait is one foreign access.
- DMEM_ARB_RR_EN undefined: fixed priority, CPU always wins. The pointer logic is removed. The loader can starve while CPU requests continuously.

## Structure
- DATA_W default and state encodings (`ARB_IDLE, `ARB_ACCESS, `ARB_DONE) go in definitions.vh, next to `WORD.
- One sub-module, arb_pick: purely combinational winner selection from cpu_req, ldr_req and the last-served pointer. It contains the DMEM_ARB_RR_EN ifdef.
- dmem_arbiter holds the FSM, counter, latches and output muxing.

## Test plan
- **CPU read, MEM_LAT=1:** cpu_req, addr 0x10, memory returns 0xDEADBEEF → cycle 1: cpu_gnt=1, mem_read=1, mem_address=0x10. Cycle 2: cpu_done=1, cpu_rdata=0xDEADBEEF. Loader outputs stay 0.
- **Loader write, MEM_LAT=1:** addr 0x20, data 0x55 → mem_write=1 for exactly 1 cycle with mem_write_data=0x55, then ldr_done. mem_read stays 0.
- **Both requesters re-requesting for 4 accesses:** with DMEM_ARB_RR_EN, grant order is C,L,C,L. Without it, order is C,C,C,C while the loader waits.
- **MEM_LAT=3 read:** strobe high in cycles 1–3, done in cycle 4. rdata equals mem_read_data sampled in cycle 3.
- **Reset in second ACCESS cycle (MEM_LAT=3):** the next cycle has all outputs 0 and no done. A CPU read issued afterwards completes with normal latency.
- **Request during DONE:** ldr_req rises while cpu_done=1 → loader granted at the second cycle after DONE, not earlier.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: default word width, FSM state
// encodings and the owner tag used for the latched grant.
package dmem_arbiter_pkg;

  localparam int WORD = 64;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_DONE   = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_LDR = 1'b1
  } owner_t;

endpackage

// File: rtl/dmem_arbiter_pick.sv
// Combinational winner selection between CPU and loader.
// DMEM_ARB_RR_EN selects round-robin against the last-served owner; otherwise CPU has fixed priority.
module arb_pick (
  input  logic cpu_req,
  input  logic ldr_req,
`ifdef DMEM_ARB_RR_EN
  input  logic last_ldr,
`endif
  output logic pick_ldr
);

`ifdef DMEM_ARB_RR_EN
  // On contention the requester not served last wins.
  assign pick_ldr = ldr_req & (~cpu_req | ~last_ldr);
`else
  assign pick_ldr = ldr_req & ~cpu_req;
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter (CPU memory stage + loader) with a MEM_LAT-cycle strobe window.
// Build option DMEM_ARB_RR_EN: round-robin instead of CPU-first fixed priority.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DATA_W  = WORD,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [DATA_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [DATA_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_gnt,
  output logic              ldr_done,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);

  localparam int            CW       = $clog2(MEM_LAT + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LAT - 1);

  arb_state_t        state_q, state_d;
  logic [CW-1:0]     cnt_q;
  owner_t            own_q;
  logic              we_q;
  logic [DATA_W-1:0] addr_q, wdata_q;
  logic [DATA_W-1:0] cpu_rdata_q, ldr_rdata_q;
  logic              any_req, grant, pick_ldr;

  assign any_req = cpu_req | ldr_req;
  assign grant   = (state_q == ARB_IDLE) & any_req;

`ifdef DMEM_ARB_RR_EN
  owner_t last_q;

  arb_pick u_pick (
    .cpu_req (cpu_req),
    .ldr_req (ldr_req),
    .last_ldr(last_q == OWN_LDR),
    .pick_ldr(pick_ldr)
  );

  always_ff @(posedge clk) begin
    if (reset)      last_q <= OWN_LDR;
    else if (grant) last_q <= pick_ldr ? OWN_LDR : OWN_CPU;
  end
`else
  arb_pick u_pick (
    .cpu_req (cpu_req),
    .ldr_req (ldr_req),
    .pick_ldr(pick_ldr)
  );
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= ARB_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    cpu_gnt        = 1'b0;
    ldr_gnt        = 1'b0;
    cpu_done       = 1'b0;
    ldr_done       = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    case (state_q)
      ARB_IDLE: if (any_req) state_d = ARB_ACCESS;
      ARB_ACCESS: begin
        cpu_gnt        = (own_q == OWN_CPU);
        ldr_gnt        = (own_q == OWN_LDR);
        mem_read       = ~we_q;
        mem_write      = we_q;
        mem_address    = addr_q;
        mem_write_data = wdata_q;
        if (cnt_q == '0) state_d = ARB_DONE;
      end
      ARB_DONE: begin
        cpu_done = (own_q == OWN_CPU);
        ldr_done = (own_q == OWN_LDR);
        state_d  = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Request fields are latched at grant so requesters may change them while waiting.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      own_q       <= OWN_CPU;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
    end else if (grant) begin
      own_q   <= pick_ldr ? OWN_LDR : OWN_CPU;
      we_q    <= pick_ldr ? ldr_we : cpu_we;
      addr_q  <= pick_ldr ? ldr_addr : cpu_addr;
      wdata_q <= pick_ldr ? ldr_wdata : cpu_wdata;
      cnt_q   <= CNT_LOAD;
    end else if (state_q == ARB_ACCESS) begin
      if (cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end else if (!we_q) begin
        if (own_q == OWN_LDR) ldr_rdata_q <= mem_read_data;
        else                  cpu_rdata_q <= mem_read_data;
      end
    end
  end

  assign cpu_rdata = cpu_rdata_q;
  assign ldr_rdata = ldr_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: two instances (MEM_LAT=1 and MEM_LAT=3) driven one at a time.
// Expected strobe/grant and done events are queued with their cycle; a negedge monitor pops and compares.
module tb_dmem_arbiter;
  localparam int W = 64;

  typedef struct {
    int g; int cyc;
    logic rd, wr, cg, lg;
    logic [W-1:0] addr, wdata;
  } mexp_t;

  typedef struct {
    int g; int cyc;
    logic cd, ld;
    logic [W-1:0] rdata;
  } dexp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic         cpu_req[2], cpu_we[2], ldr_req[2], ldr_we[2];
  logic [W-1:0] cpu_addr[2], cpu_wdata[2], ldr_addr[2], ldr_wdata[2];
  logic         cpu_gnt[2], cpu_done[2], ldr_gnt[2], ldr_done[2], mem_read[2], mem_write[2];
  logic [W-1:0] cpu_rdata[2], ldr_rdata[2], mem_address[2], mem_write_data[2], mem_read_data[2];
  logic [W-1:0] rdv[2];
  int           rcnt[2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    dmem_arbiter #(.DATA_W(W), .MEM_LAT(g == 0 ? 1 : 3)) u_dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req[g]), .cpu_we(cpu_we[g]), .cpu_addr(cpu_addr[g]), .cpu_wdata(cpu_wdata[g]),
      .cpu_gnt(cpu_gnt[g]), .cpu_done(cpu_done[g]), .cpu_rdata(cpu_rdata[g]),
      .ldr_req(ldr_req[g]), .ldr_we(ldr_we[g]), .ldr_addr(ldr_addr[g]), .ldr_wdata(ldr_wdata[g]),
      .ldr_gnt(ldr_gnt[g]), .ldr_done(ldr_done[g]), .ldr_rdata(ldr_rdata[g]),
      .mem_read(mem_read[g]), .mem_write(mem_write[g]), .mem_address(mem_address[g]),
      .mem_write_data(mem_write_data[g]), .mem_read_data(mem_read_data[g])
    );
    // Read data changes every strobe cycle so an early or late capture is visible.
    assign mem_read_data[g] = mem_read[g] ? rdv[g] + W'(rcnt[g]) : '0;
  end

  always @(posedge clk)
    for (int g = 0; g < 2; g++) rcnt[g] <= mem_read[g] ? rcnt[g] + 1 : 0;

  mexp_t mq[$];
  dexp_t dq[$];
  int nvec = 0, nbad = 0;

  function automatic int lat(int g);
    return (g == 0) ? 1 : 3;
  endfunction

  task automatic go(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Queue the events of one access whose request is sampled in IDLE at cycle s.
  task automatic push_acc(int g, int s, bit ldr, bit we, logic [W-1:0] addr, logic [W-1:0] wdata,
                          logic [W-1:0] rexp);
    for (int i = 1; i <= lat(g); i++)
      mq.push_back('{g: g, cyc: s + i, rd: !we, wr: we, cg: !ldr, lg: ldr, addr: addr, wdata: wdata});
    dq.push_back('{g: g, cyc: s + lat(g) + 1, cd: !ldr, ld: ldr, rdata: rexp});
  endtask

  task automatic zero_chk(int g, string nm);
    logic [2*W+5:0] act;
    act = {cpu_gnt[g], ldr_gnt[g], cpu_done[g], ldr_done[g], mem_read[g], mem_write[g],
           mem_address[g], mem_write_data[g]};
    nvec++;
    if (act != '0) begin
      nbad++;
      $display("FAIL %s g=%0d outputs=%h want all zero", nm, g, act);
    end
  endtask

  task automatic val_chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    mexp_t  m;
    dexp_t  d;
    logic [W-1:0] rd;
    for (int g = 0; g < 2; g++) begin
      if (mem_read[g] && mem_write[g]) begin
        nvec++; nbad++;
        $display("FAIL strobe_excl g=%0d cyc=%0d both strobes high", g, cyc);
      end
      if (mem_read[g] || mem_write[g] || cpu_gnt[g] || ldr_gnt[g]) begin
        nvec++;
        if (mq.size() == 0) begin
          nbad++;
          $display("FAIL mem_unexpected g=%0d cyc=%0d rd=%b wr=%b cg=%b lg=%b", g, cyc,
                   mem_read[g], mem_write[g], cpu_gnt[g], ldr_gnt[g]);
        end else begin
          m = mq.pop_front();
          if (m.g != g || m.cyc != cyc || m.rd !== mem_read[g] || m.wr !== mem_write[g] ||
              m.cg !== cpu_gnt[g] || m.lg !== ldr_gnt[g] || m.addr !== mem_address[g] ||
              m.wdata !== mem_write_data[g]) begin
            nbad++;
            $display("FAIL mem g=%0d cyc=%0d got rd=%b wr=%b cg=%b lg=%b a=%h wd=%h want g=%0d cyc=%0d rd=%b wr=%b cg=%b lg=%b a=%h wd=%h",
                     g, cyc, mem_read[g], mem_write[g], cpu_gnt[g], ldr_gnt[g], mem_address[g],
                     mem_write_data[g], m.g, m.cyc, m.rd, m.wr, m.cg, m.lg, m.addr, m.wdata);
          end
        end
      end
      if (cpu_done[g] || ldr_done[g]) begin
        nvec++;
        if (dq.size() == 0) begin
          nbad++;
          $display("FAIL done_unexpected g=%0d cyc=%0d cd=%b ld=%b", g, cyc, cpu_done[g], ldr_done[g]);
        end else begin
          d  = dq.pop_front();
          rd = d.cd ? cpu_rdata[g] : ldr_rdata[g];
          if (d.g != g || d.cyc != cyc || d.cd !== cpu_done[g] || d.ld !== ldr_done[g] ||
              rd !== d.rdata) begin
            nbad++;
            $display("FAIL done g=%0d cyc=%0d got cd=%b ld=%b rdata=%h want g=%0d cyc=%0d cd=%b ld=%b rdata=%h",
                     g, cyc, cpu_done[g], ldr_done[g], rd, d.g, d.cyc, d.cd, d.ld, d.rdata);
          end
        end
      end
    end
  end

  initial begin
    int s;
    reset = 1'b1;
    for (int g = 0; g < 2; g++) begin
      cpu_req[g] = 0; cpu_we[g] = 0; cpu_addr[g] = '0; cpu_wdata[g] = '0;
      ldr_req[g] = 0; ldr_we[g] = 0; ldr_addr[g] = '0; ldr_wdata[g] = '0;
      rdv[g] = '0;
    end
    go(2);
    reset = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      zero_chk(g, "reset_state");
      val_chk("reset_cpu_rdata", cpu_rdata[g], '0);
      val_chk("reset_ldr_rdata", ldr_rdata[g], '0);
    end
    go(1);

    // CPU read, MEM_LAT=1
    s = cyc; rdv[0] = 64'hDEADBEEF;
    cpu_req[0] = 1; cpu_we[0] = 0; cpu_addr[0] = 64'h10; cpu_wdata[0] = '0;
    push_acc(0, s, 0, 0, 64'h10, 64'h0, 64'hDEADBEEF);
    go(3); cpu_req[0] = 0;
    val_chk("cpu_rdata_hold", cpu_rdata[0], 64'hDEADBEEF);
    val_chk("ldr_rdata_untouched", ldr_rdata[0], '0);

    // Loader write, MEM_LAT=1
    s = cyc;
    ldr_req[0] = 1; ldr_we[0] = 1; ldr_addr[0] = 64'h20; ldr_wdata[0] = 64'h55;
    push_acc(0, s, 1, 1, 64'h20, 64'h55, 64'h0);
    go(3); ldr_req[0] = 0;

    // Both requesters re-requesting for four accesses
    s = cyc; rdv[0] = 64'h77;
    cpu_we[0] = 1; cpu_addr[0] = 64'h100; cpu_wdata[0] = 64'hAA;
    ldr_we[0] = 0; ldr_addr[0] = 64'h200; ldr_wdata[0] = 64'h0;
    cpu_req[0] = 1; ldr_req[0] = 1;
`ifdef DMEM_ARB_RR_EN
    push_acc(0, s,     0, 1, 64'h100, 64'hAA, 64'hDEADBEEF);
    push_acc(0, s + 3, 1, 0, 64'h200, 64'h0,  64'h77);
    push_acc(0, s + 6, 0, 1, 64'h100, 64'hAA, 64'hDEADBEEF);
    push_acc(0, s + 9, 1, 0, 64'h200, 64'h0,  64'h77);
    go(12); cpu_req[0] = 0; ldr_req[0] = 0;
`else
    for (int i = 0; i < 4; i++) push_acc(0, s + 3 * i, 0, 1, 64'h100, 64'hAA, 64'hDEADBEEF);
    push_acc(0, s + 12, 1, 0, 64'h200, 64'h0, 64'h77);
    go(12); cpu_req[0] = 0;
    go(3);  ldr_req[0] = 0;
`endif

    // MEM_LAT=3 read; request fields changed mid-access must be ignored
    s = cyc; rdv[1] = 64'h1000;
    cpu_req[1] = 1; cpu_we[1] = 0; cpu_addr[1] = 64'h30; cpu_wdata[1] = 64'h9;
    push_acc(1, s, 0, 0, 64'h30, 64'h9, 64'h1002);
    go(1); cpu_addr[1] = 64'h38; cpu_wdata[1] = 64'h0;
    go(4); cpu_req[1] = 0;

    // Reset during the second ACCESS cycle, then a clean read
    s = cyc;
    cpu_req[1] = 1; cpu_we[1] = 0; cpu_addr[1] = 64'h40; cpu_wdata[1] = 64'h0;
    for (int i = 1; i <= 2; i++)
      mq.push_back('{g: 1, cyc: s + i, rd: 1, wr: 0, cg: 1, lg: 0, addr: 64'h40, wdata: 64'h0});
    go(2); reset = 1'b1; cpu_req[1] = 0;
    go(1); reset = 1'b0;
    @(negedge clk);
    zero_chk(1, "abort_outputs");
    val_chk("abort_cpu_rdata", cpu_rdata[1], '0);
    go(1);
    s = cyc; rdv[1] = 64'h2000;
    cpu_req[1] = 1; cpu_addr[1] = 64'h48;
    push_acc(1, s, 0, 0, 64'h48, 64'h0, 64'h2002);
    go(5); cpu_req[1] = 0;

    // Loader request raised during CPU done waits for the next IDLE sample
    s = cyc; rdv[0] = 64'h300;
    cpu_req[0] = 1; cpu_we[0] = 0; cpu_addr[0] = 64'h60; cpu_wdata[0] = 64'h0;
    ldr_we[0] = 1; ldr_addr[0] = 64'h68; ldr_wdata[0] = 64'h66;
    push_acc(0, s,     0, 0, 64'h60, 64'h0,  64'h300);
    push_acc(0, s + 3, 1, 1, 64'h68, 64'h66, 64'h0);
    go(2); ldr_req[0] = 1;
    go(1); cpu_req[0] = 0;
    go(3); ldr_req[0] = 0;

    go(4);
    nvec++;
    if (mq.size() != 0 || dq.size() != 0) begin
      nbad++;
      $display("FAIL missing_events mem_left=%0d done_left=%0d want 0", mq.size(), dq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
